ring_rotate_ctrl: RTL and testbench
===================================

Name: ring_rotate_ctrl

Overview:
Sequencer for a WIDTH-bit circular shift register. Accepts a command (pattern, step count, direction) over a valid/ready handshake and loads the pattern. Rotates it one position per clock for the requested number of steps, then presents the result over a second valid/ready handshake. Sits between a command source (FSM or testbench driver) and any consumer of rotated patterns.

Parameters:
WIDTH, 6, ring register width in bits (≥2)
CNT_W, 4, width of step-count field; max steps = 2^CNT_W-1

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept command
cmd_data  input  WIDTH  pattern to load
cmd_steps  input  CNT_W  number of single-position rotations
cmd_dir  input  1  0 = right (q[i]<=q[i+1], q[MSB]<=q[0]), 1 = left (q[i]<=q[i-1], q[0]<=q[MSB])
abort  input  1  cancel rotation in progress
busy  output  1  high in SHIFT or DONE
q  output  WIDTH  live ring register contents
res_valid  output  1  result available
res_data  output  WIDTH  rotated result (equals q while res_valid)
res_ready  input  1  consumer accepts result

Behaviour:
- Reset (rst_n low, async): state IDLE, q=0, count=0, dir=0, cmd_ready=1, busy=0, res_valid=0, res_data=0.
- States: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready at an edge (accept edge): q<=cmd_data, count<=cmd_steps, dir latched. Next state SHIFT if cmd_steps!=0, else DONE.
- SHIFT: cmd_ready=0. Each edge rotates q one position in latched dir, count decrements. When count==1 at the edge, the final rotation occurs and state goes to DONE.
- Latency: res_valid rises N edges after the accept edge for N≥1; for N=0 it rises on the accept edge itself (one cycle later than cmd accept cycle).
- DONE: res_valid=1, res_data=q, q held stable. On res_valid&&res_ready, go to IDLE; q keeps its value. cmd_ready stays 0 in DONE, so there is no same-cycle command accept.
- abort: sampled only in SHIFT. If high, the state goes to IDLE at that edge. No rotation occurs on that edge, q holds its partial value, and no result is produced. abort is ignored in IDLE and DONE.
- Inputs cmd_data, cmd_steps and cmd_dir are sampled only on the accept edge. Later changes have no effect.
- N=WIDTH returns the original pattern. N>WIDTH wraps modulo WIDTH through plain repeated rotation, with no shortcut.
- Reset mid-SHIFT or mid-DONE: immediate return to reset values, and any pending result is lost.

Optional Feature:
Macro RING_TWIST_EN. When defined, adds input cmd_twist (1 bit), latched on the accept edge. If twist=1, the wrapped-around bit is inverted: right shift uses q[MSB]<=~q[0], left shift uses q[0]<=~q[MSB] (Johnson counter, period 2·WIDTH). When undefined, the port is absent and rotation is always plain.

Test Plan:
- Right rotate: cmd_data=6'b000001, steps=1, dir=0 → res_valid one edge after accept, res_data=6'b100000.
- Left rotate: data=6'b000001, steps=2, dir=1 → res_data=6'b000100 after 2 edges. Steps=6 on data 6'b101100 → res_data=6'b101100.
- Zero steps and backpressure: steps=0, data=6'b110011, res_ready=0 for 5 cycles → res_valid held high, res_data=6'b110011, cmd_ready=0. Raising res_ready → IDLE next edge, cmd_ready=1.
- Abort: data=6'b000011, dir=0, steps=10, abort high in 3rd SHIFT cycle → IDLE, no res_valid pulse, q=6'b110000 (2 rotations done).
- Async reset: assert rst_n=0 mid-SHIFT between clock edges → q=0, busy=0, cmd_ready=1 immediately, without waiting for a clock edge.
- RING_TWIST_EN: data=6'b000000, dir=0, twist=1, steps=6 → res_data=6'b111111; steps=12 → 6'b000000.

Source files
------------

// File: rtl/ring_rotate_ctrl_if.sv
// Command/result bus for ring_rotate_ctrl.
// Optional macro RING_TWIST_EN adds the cmd_twist field (Johnson-style wrap inversion).
interface ring_rotate_ctrl_if #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;
`ifdef RING_TWIST_EN
    logic             cmd_twist;
`endif
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_ready;

    // Command source / result consumer side
    modport master (
`ifdef RING_TWIST_EN
        output cmd_twist,
`endif
        output cmd_valid,
        output cmd_data,
        output cmd_steps,
        output cmd_dir,
        input  cmd_ready,
        input  res_valid,
        input  res_data,
        output res_ready
    );

    // Rotation controller side
    modport slave (
`ifdef RING_TWIST_EN
        input  cmd_twist,
`endif
        input  cmd_valid,
        input  cmd_data,
        input  cmd_steps,
        input  cmd_dir,
        output cmd_ready,
        output res_valid,
        output res_data,
        input  res_ready
    );
endinterface

// File: rtl/ring_rotate_ctrl.sv
// ring_rotate_ctrl: loads a pattern, rotates it one position per clock for the
// commanded number of steps, then offers the result on a valid/ready handshake.
// Optional macro RING_TWIST_EN: latch cmd_twist and invert the wrapped bit.
module ring_rotate_ctrl #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ring_rotate_ctrl_if.slave    bus,
    input  logic                 abort,
    output logic                 busy,
    output logic [WIDTH-1:0]     q
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             dir;
    logic             dir_nxt;
    logic             twist;
    logic [WIDTH-1:0] rot_c;
    logic             wrap_c;

    logic             cmd_ready_r;
    logic             cmd_ready_nxt;
    logic             busy_r;
    logic             busy_nxt;
    logic             res_valid_r;
    logic             res_valid_nxt;
    logic [WIDTH-1:0] res_data_r;
    logic [WIDTH-1:0] res_data_nxt;

`ifdef RING_TWIST_EN
    logic             twist_nxt;
`else
    assign twist = 1'b0;
`endif

    // One-position rotation of the live ring in the latched direction
    always_comb begin
        wrap_c = (dir ? q_r[WIDTH-1] : q_r[0]) ^ twist;
        if (dir) begin
            rot_c = {q_r[WIDTH-2:0], wrap_c};
        end else begin
            rot_c = {wrap_c, q_r[WIDTH-1:1]};
        end
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_nxt = state;
        q_nxt     = q_r;
        count_nxt = count;
        dir_nxt   = dir;
`ifdef RING_TWIST_EN
        twist_nxt = twist;
`endif
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_r) begin
                    q_nxt     = bus.cmd_data;
                    count_nxt = bus.cmd_steps;
                    dir_nxt   = bus.cmd_dir;
`ifdef RING_TWIST_EN
                    twist_nxt = bus.cmd_twist;
`endif
                    state_nxt = (bus.cmd_steps != CNT_W'(0)) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                // abort wins over the rotation on the same edge
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    q_nxt     = rot_c;
                    count_nxt = count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (res_valid_r && bus.res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        cmd_ready_nxt = (state_nxt == ST_IDLE);
        busy_nxt      = (state_nxt != ST_IDLE);
        res_valid_nxt = (state_nxt == ST_DONE);
        res_data_nxt  = (state_nxt == ST_DONE) ? q_nxt : '0;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ring, step counter and latched command attributes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r   <= '0;
            count <= '0;
            dir   <= 1'b0;
        end else begin
            q_r   <= q_nxt;
            count <= count_nxt;
            dir   <= dir_nxt;
        end
    end

`ifdef RING_TWIST_EN
    // Latched wrap-inversion flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            twist <= 1'b0;
        end else begin
            twist <= twist_nxt;
        end
    end
`endif

    // Registered handshake and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
        end else begin
            cmd_ready_r <= cmd_ready_nxt;
            busy_r      <= busy_nxt;
            res_valid_r <= res_valid_nxt;
            res_data_r  <= res_data_nxt;
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;
    assign busy          = busy_r;
    assign q             = q_r;

endmodule

// File: tb/tb_ring_rotate_ctrl.sv
// Directed bench for ring_rotate_ctrl (WIDTH=6, CNT_W=4).
module tb_ring_rotate_ctrl;

    localparam int unsigned WIDTH = 6;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             abort;
    logic             busy;
    logic [WIDTH-1:0] q;

    int checks   = 0;
    int failures = 0;

    ring_rotate_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    ring_rotate_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .abort (abort),
        .busy  (busy),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] steps;
        logic             dir;
        logic             twist;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one command, wait for the result, check latency/value, then accept it
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        chk($sformatf("v%0d_cmd_ready_idle", idx), 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = v.data;
        bus.cmd_steps = v.steps;
        bus.cmd_dir   = v.dir;
`ifdef RING_TWIST_EN
        bus.cmd_twist = v.twist;
`endif
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = ~v.data;
        bus.cmd_steps = ~v.steps;
        bus.cmd_dir   = ~v.dir;
        lat = 0;
        while (!bus.res_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.steps));
        chk($sformatf("v%0d_res_data", idx), 32'(bus.res_data), 32'(v.exp));
        chk($sformatf("v%0d_q", idx), 32'(q), 32'(v.exp));
        chk($sformatf("v%0d_busy_done", idx), 32'(busy), 32'd1);
        chk($sformatf("v%0d_cmd_ready_done", idx), 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        chk($sformatf("v%0d_res_valid_drop", idx), 32'(bus.res_valid), 32'd0);
        chk($sformatf("v%0d_cmd_ready_back", idx), 32'(bus.cmd_ready), 32'd1);
        chk($sformatf("v%0d_q_kept", idx), 32'(q), 32'(v.exp));
    endtask

    initial begin
        rst_n         = 1'b0;
        abort         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.cmd_steps = '0;
        bus.cmd_dir   = 1'b0;
`ifdef RING_TWIST_EN
        bus.cmd_twist = 1'b0;
`endif
        bus.res_ready = 1'b0;

        //                data       steps  dir   twist exp
        vecs.push_back({6'b000001, 4'd1,  1'b0, 1'b0, 6'b100000});
        vecs.push_back({6'b000001, 4'd2,  1'b1, 1'b0, 6'b000100});
        vecs.push_back({6'b101100, 4'd6,  1'b1, 1'b0, 6'b101100});
        vecs.push_back({6'b101100, 4'd6,  1'b0, 1'b0, 6'b101100});
        vecs.push_back({6'b110011, 4'd0,  1'b0, 1'b0, 6'b110011});
        vecs.push_back({6'b000001, 4'd7,  1'b0, 1'b0, 6'b100000});
        vecs.push_back({6'b100101, 4'd15, 1'b1, 1'b0, 6'b101100});
        vecs.push_back({6'b011010, 4'd3,  1'b0, 1'b0, 6'b010011});
`ifdef RING_TWIST_EN
        vecs.push_back({6'b000000, 4'd6,  1'b0, 1'b1, 6'b111111});
        vecs.push_back({6'b000000, 4'd12, 1'b0, 1'b1, 6'b000000});
        vecs.push_back({6'b000001, 4'd1,  1'b1, 1'b1, 6'b000011});
`endif

        // Reset values
        #12;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_res_data", 32'(bus.res_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Zero steps with backpressure; commands and abort in DONE are ignored
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 6'b110011;
        bus.cmd_steps = 4'd0;
        bus.cmd_dir   = 1'b0;
        @(posedge clk);
        #1;
        bus.cmd_data  = 6'b001100;
        bus.cmd_steps = 4'd3;
        abort         = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_res_valid", c), 32'(bus.res_valid), 32'd1);
            chk($sformatf("bp%0d_res_data", c), 32'(bus.res_data), 32'h33);
            chk($sformatf("bp%0d_cmd_ready", c), 32'(bus.cmd_ready), 32'd0);
            chk($sformatf("bp%0d_q", c), 32'(q), 32'h33);
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        abort         = 1'b0;
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        chk("bp_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("bp_release_res_valid", 32'(bus.res_valid), 32'd0);
        chk("bp_release_busy", 32'(busy), 32'd0);

        // Abort in the third SHIFT cycle after two rotations
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 6'b000011;
        bus.cmd_steps = 4'd10;
        bus.cmd_dir   = 1'b0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        chk("ab_busy_shift", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("ab_q_rot1", 32'(q), 32'b100001);
        @(posedge clk);
        #1;
        chk("ab_q_rot2", 32'(q), 32'b110000);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("ab_q_partial", 32'(q), 32'b110000);
        chk("ab_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("ab_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("ab_no_result%0d", c), 32'(bus.res_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("ab_q_hold", 32'(q), 32'b110000);

        // Async reset between edges in the middle of SHIFT
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 6'b010101;
        bus.cmd_steps = 4'd10;
        bus.cmd_dir   = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("ar_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_q", 32'(q), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("ar_res_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("ar_no_result", 32'(bus.res_valid), 32'd0);
        chk("ar_idle", 32'(busy), 32'd0);

        // Normal operation resumes after the reset
        run_vec({6'b000001, 4'd1, 1'b0, 1'b0, 6'b100000}, 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
